// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports and status.
// The master drives writes and read addresses; the slave (the file) returns data and status.
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NR    = 2,
    parameter int NW    = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NW-1:0]       we;
    logic [NW*AW-1:0]    waddr;
    logic [NW*WIDTH-1:0] wdata;
    logic [NR*AW-1:0]    raddr;
    logic [NR*WIDTH-1:0] rdata;
    logic                ready;
    logic                wr_conflict;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata, ready, wr_conflict
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata, ready, wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NW synchronous writes, NR combinational reads, and a
// clear sweep after reset that zeroes one entry per cycle before ready is raised.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state;
    logic [AW-1:0]    ptr;
    logic             ready_q;
    logic             conflict_q;
    logic             collide;
    logic [NR*WIDTH-1:0] rdata_c;
    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NW; i++) begin
            for (int k = i + 1; k < NW; k++) begin
                if (bus.we[i] && bus.we[k] &&
                    bus.waddr[i*AW +: AW] == bus.waddr[k*AW +: AW])
                    collide = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            ptr        <= '0;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= (state == RUN) && collide;
            if (state == CLEAR) begin
                ptr <= ptr + AW'(1);
                if (ptr == AW'(DEPTH - 1)) begin
                    state   <= RUN;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    // No reset on the array: the sweep is the only way it gets cleared.
    // Later ports are assigned last, so the highest-index port wins a collision.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (bus.we[i] && !(ZERO_REG != 0 && bus.waddr[i*AW +: AW] == '0))
                    mem[bus.waddr[i*AW +: AW]] <= bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] v;
        rdata_c = '0;
        ra      = '0;
        v       = '0;
        for (int j = 0; j < NR; j++) begin
            ra = bus.raddr[j*AW +: AW];
            v  = '0;
            if (state == RUN && !(ZERO_REG != 0 && ra == '0)) begin
                v = mem[ra];
                if (BYPASS != 0) begin
                    for (int i = 0; i < NW; i++) begin
                        if (bus.we[i] && bus.waddr[i*AW +: AW] == ra)
                            v = bus.wdata[i*WIDTH +: WIDTH];
                    end
                end
            end
            rdata_c[j*WIDTH +: WIDTH] = v;
        end
    end

    assign bus.rdata       = rdata_c;
    assign bus.ready       = ready_q;
    assign bus.wr_conflict = conflict_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Drives two register files (zero-reg + bypass, and plain no-bypass) with identical stimulus
// and compares them against an array-based reference of the file's documented behaviour.
module tb_regfile_mp;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = $clog2(D);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NW-1:0]   we    = '0;
    logic [NW*AW-1:0] waddr = '0;
    logic [NW*W-1:0] wdata = '0;
    logic [NR*AW-1:0] raddr = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NR(NR), .NW(NW)) ifa ();
    regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NR(NR), .NW(NW)) ifb ();

    assign ifa.we = we;  assign ifa.waddr = waddr;  assign ifa.wdata = wdata;  assign ifa.raddr = raddr;
    assign ifb.we = we;  assign ifb.waddr = waddr;  assign ifb.wdata = wdata;  assign ifb.raddr = raddr;

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    regfile_mp #(.WIDTH(W), .DEPTH(D), .NR(NR), .NW(NW), .ZERO_REG(0), .BYPASS(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Reference: contents become all-zero once DEPTH non-reset edges have passed.
    logic [W-1:0] ma [D];
    logic [W-1:0] mb [D];
    bit rdy_m  = 1'b0;
    int cnt_m  = 0;
    bit conf_m = 1'b0;

    task automatic ck(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int wa(input int p);
        return int'(waddr[p*AW +: AW]);
    endfunction

    function automatic int ra(input int p);
        return int'(raddr[p*AW +: AW]);
    endfunction

    function automatic bit collision();
        int hits [D];
        for (int a = 0; a < D; a++) hits[a] = 0;
        for (int i = 0; i < NW; i++) if (we[i]) hits[wa(i)]++;
        for (int a = 0; a < D; a++) if (hits[a] > 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] exp_rd(input bit is_a, input int p);
        logic [W-1:0] v;
        int a;
        a = ra(p);
        if (!rdy_m) return '0;
        if (is_a && a == 0) return '0;
        v = is_a ? ma[a] : mb[a];
        if (is_a) begin
            for (int i = 0; i < NW; i++)
                if (we[i] && wa(i) == a) v = wdata[i*W +: W];
        end
        return v;
    endfunction

    task automatic model_update();
        if (rst) begin
            rdy_m = 1'b0; cnt_m = 0; conf_m = 1'b0;
        end else begin
            conf_m = rdy_m && collision();
            if (!rdy_m) begin
                cnt_m++;
                if (cnt_m == D) begin
                    rdy_m = 1'b1;
                    for (int a = 0; a < D; a++) begin ma[a] = '0; mb[a] = '0; end
                end
            end else begin
                for (int i = 0; i < NW; i++) begin
                    if (we[i]) begin
                        mb[wa(i)] = wdata[i*W +: W];
                        if (wa(i) != 0) ma[wa(i)] = wdata[i*W +: W];
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        ck("a_ready", W'(ifa.ready), W'(rdy_m));
        ck("b_ready", W'(ifb.ready), W'(rdy_m));
        ck("a_conflict", W'(ifa.wr_conflict), W'(conf_m));
        ck("b_conflict", W'(ifb.wr_conflict), W'(conf_m));
        for (int p = 0; p < NR; p++) begin
            ck($sformatf("a_rdata%0d", p), ifa.rdata[p*W +: W], exp_rd(1'b1, p));
            ck($sformatf("b_rdata%0d", p), ifb.rdata[p*W +: W], exp_rd(1'b0, p));
        end
    endtask

    task automatic tick(input bit chk);
        @(negedge clk);
        if (chk) check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        we = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [W-1:0] d);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*W +: W] = d;
    endtask

    task automatic rd(input int p, input int a);
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic rand_inputs(input int amax);
        for (int i = 0; i < NW; i++) begin
            we[i] = 1'($urandom_range(0, 1));
            waddr[i*AW +: AW] = AW'($urandom_range(0, amax));
            wdata[i*W +: W] = $urandom;
        end
        for (int j = 0; j < NR; j++) raddr[j*AW +: AW] = AW'($urandom_range(0, amax));
    endtask

    initial begin
        // Reset and the first sweep.
        rst = 1'b1; idle();
        tick(1'b0);
        tick(1'b1);
        rst = 1'b0;
        for (int i = 0; i < D; i++) begin
            rand_inputs(D - 1);
            tick(1'b1);
        end
        ck("ready_after_sweep", W'(ifa.ready), W'(1));
        idle(); rd(0, 5); rd(1, 5);

        // Preload, then a reset that is restarted mid-sweep with writes in flight.
        wr(0, 5, 32'hDEADBEEF);
        tick(1'b1);
        idle(); rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_inputs(D - 1);
            tick(1'b1);
        end
        rst = 1'b1; idle();
        tick(1'b1);
        rst = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (i == D - 1) ck("ready_low_last", W'(ifa.ready), W'(0));
            rand_inputs(D - 1);
            rd(0, 5);
            tick(1'b1);
        end
        ck("ready_after_restart", W'(ifa.ready), W'(1));
        idle(); rd(0, 5); rd(1, 5); #1;
        ck("a_read5_cleared", ifa.rdata[0 +: W], 32'h0);
        ck("b_read5_cleared", ifb.rdata[W +: W], 32'h0);
        tick(1'b1);

        // Dual write to distinct addresses.
        wr(0, 3, 32'h11); wr(1, 7, 32'h22);
        tick(1'b1);
        idle(); rd(0, 3); rd(1, 7); #1;
        ck("dual_rd0", ifb.rdata[0 +: W], 32'h11);
        ck("dual_rd1", ifb.rdata[W +: W], 32'h22);
        ck("dual_noconf", W'(ifa.wr_conflict), W'(0));
        tick(1'b1);

        // Collision: highest-index port wins, flag lasts one cycle.
        wr(0, 9, 32'hAAAA); wr(1, 9, 32'h5555);
        tick(1'b1);
        idle(); rd(0, 9); rd(1, 9); #1;
        ck("coll_data_a", ifa.rdata[0 +: W], 32'h5555);
        ck("coll_data_b", ifb.rdata[W +: W], 32'h5555);
        ck("coll_flag", W'(ifa.wr_conflict), W'(1));
        tick(1'b1);
        ck("coll_flag_drop", W'(ifa.wr_conflict), W'(0));

        // Bypass versus stored value.
        wr(0, 4, 32'h1);
        tick(1'b1);
        idle(); wr(0, 4, 32'h99); rd(0, 4); #1;
        ck("bypass_hit", ifa.rdata[0 +: W], 32'h99);
        ck("nobypass_old", ifb.rdata[0 +: W], 32'h1);
        tick(1'b1);
        idle(); #1;
        ck("nobypass_next", ifb.rdata[0 +: W], 32'h99);
        tick(1'b1);

        // Zero register ignores writes, including a colliding pair on address 0.
        wr(0, 0, 32'hFFFF); wr(1, 0, 32'h1234); rd(0, 0); rd(1, 0); #1;
        ck("zero_same0", ifa.rdata[0 +: W], 32'h0);
        ck("zero_same1", ifa.rdata[W +: W], 32'h0);
        tick(1'b1);
        idle(); #1;
        ck("zero_after0", ifa.rdata[0 +: W], 32'h0);
        ck("zero_after1", ifa.rdata[W +: W], 32'h0);
        ck("zero_conflict", W'(ifa.wr_conflict), W'(1));
        ck("plain_reg0", ifb.rdata[0 +: W], 32'h1234);
        tick(1'b1);

        // Random traffic over a narrow address range to provoke collisions and bypass hits.
        for (int i = 0; i < 600; i++) begin
            rand_inputs(7);
            rst = ($urandom_range(0, 149) == 0);
            tick(1'b1);
        end
        rst = 1'b0; idle();
        tick(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parameterised multi-port register file, the successor to the single-write/dual-read register file in the core datapath. It is built for superscalar and dual-issue experiments and provides:
- NR asynchronous read ports and NW synchronous write ports.
- Optional hardwired-zero entry 0.
- Optional same-cycle write-to-read bypass.
- A reset-driven clear sequencer that zeroes every entry, one per cycle, before the file reports ready.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 32, number of entries (power of 2, >=2); AW = $clog2(DEPTH)
NR, 2, number of read ports (>=1)
NW, 2, number of write ports (>=1)
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes
BYPASS, 1, 1 = a read hits same-cycle write data; 0 = a read returns the stored (pre-write) value

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset; starts the clear sweep
we  input  NW  per-port write enable
waddr  input  NW*AW  write addresses; port i occupies bits [i*AW +: AW]
wdata  input  NW*WIDTH  write data; port i occupies bits [i*WIDTH +: WIDTH]
raddr  input  NR*AW  read addresses; port j occupies bits [j*AW +: AW]
rdata  output  NR*WIDTH  read data; port j occupies bits [j*WIDTH +: WIDTH]
ready  output  1  high when the file accepts writes and returns valid reads
wr_conflict  output  1  registered; high for one cycle after two or more enabled write ports targeted the same address

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM has two states, CLEAR and RUN.
- Reset action: rst=1 at a clock edge forces state=CLEAR, clear pointer ptr=0, ready=0, wr_conflict=0. This applies from any state, including mid-sweep, which restarts the sweep at 0.
- CLEAR (rst=0), each cycle:
  - mem[ptr] <= 0; ptr increments.
  - After the edge that writes ptr=DEPTH-1, state goes to RUN and ready becomes 1.
  - ready therefore rises exactly DEPTH edges after the first edge with rst=0.
- During CLEAR:
  - All we are ignored.
  - All rdata are forced to 0.
  - wr_conflict stays 0.
- RUN, writes:
  - For each port i with we[i]=1, mem[waddr_i] <= wdata_i at the edge.
  - If ZERO_REG=1 and waddr_i=0, that write is dropped.
- Write-write collision: when several enabled ports target the same address, the highest-index port wins. wr_conflict=1 on the following cycle; otherwise wr_conflict=0. A collision on address 0 with ZERO_REG=1 still raises wr_conflict.
- RUN, reads are combinational (zero latency) from raddr_j.
  - If ZERO_REG=1 and raddr_j=0: rdata_j=0, regardless of writes.
  - Else if BYPASS=1 and some enabled port targets raddr_j in the same cycle: rdata_j = that port's wdata, using the highest-index match.
  - Else: rdata_j = mem[raddr_j].
- Read ports are fully independent. Any number may read the same address.
- Memory contents before the first completed sweep are undefined. ready=0 covers that window.
- No reset fan-out to the array other than the sweep. The array must map to distributed RAM/flops without a per-entry reset network.

Test Plan:
- Reset/clear: DEPTH=32; preload entry 5 = 0xDEADBEEF; pulse rst 1 cycle -> ready=0 for 32 edges and rises on the 32nd; then read addr 5 -> 0x00000000.
- Reset mid-sweep: assert rst again 10 cycles into CLEAR -> ptr restarts; ready rises 32 edges after that second rst deasserts; writes issued during CLEAR are not stored.
- Dual write, no conflict: we=2'b11, waddr0=3/wdata0=0x11, waddr1=7/wdata1=0x22 -> next cycle raddr0=3 gives 0x11, raddr1=7 gives 0x22; wr_conflict=0.
- Collision priority: we=2'b11, both waddr=9, wdata0=0xAAAA, wdata1=0x5555 -> mem[9]=0x5555; wr_conflict=1 for exactly one cycle.
- Bypass: BYPASS=1, mem[4]=0x1; same cycle we0=1, waddr0=4, wdata0=0x99, raddr0=4 -> rdata0=0x99 combinationally. Repeat with BYPASS=0 -> rdata0=0x1, then 0x99 next cycle.
- Zero register: ZERO_REG=1; write 0xFFFF to addr 0 with BYPASS=1 while reading addr 0 on all ports -> every rdata=0 that cycle and after.
